uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter WIDTH, default 64: frame payload bits, sent LSB first; bit WIDTH-1 is the odd-parity bit; WIDTH >= 2.
REQ-002 Parameter OVERSAMPLE, default 4: clk cycles per bit; even; >= 2.
REQ-003 Parameter FIFO_DEPTH, default 4: received-word FIFO entries; power of 2; >= 2.
REQ-004 Port clk, input, 1: receive clock.
REQ-005 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port rx_in, input, 1: asynchronous serial line; idle high.
REQ-007 Port rd_en, input, 1: pop the FIFO head.
REQ-008 Port rd_data, output, WIDTH: FIFO head word, first-word-fall-through.
REQ-009 Port rd_parity_err, output, 1: parity flag stored with the head word.
REQ-010 Port fifo_empty, output, 1: FIFO holds no words.
REQ-011 Port fifo_count, output, $clog2(FIFO_DEPTH+1): number of stored words.
REQ-012 Port busy, output, 1: high whenever state != IDLE.
REQ-013 Port framing_error, output, 1: sticky; bad stop bit seen.
REQ-014 Port overflow, output, 1: sticky; word dropped because the FIFO was full.
REQ-015 Port clr_errors, input, 1: clears framing_error and overflow.

Function
REQ-016 rx_in SHALL pass through a 2-flop synchronizer (reset value 1); rx_s is the second flop output, and all decisions SHALL use rx_s.
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_IDLE, plus a bit-timer cnt and a bit index idx.
REQ-018 IDLE: on rx_s==0 -> START, cnt<=1.
REQ-019 START: cnt increments every clk; at cnt==OVERSAMPLE/2 sample rx_s.
- rx_s==0: -> DATA, cnt<=1, idx<=0.
- rx_s==1: glitch; -> IDLE; nothing stored, no flag set.
REQ-020 DATA: at cnt==OVERSAMPLE, shift[idx]<=rx_s and cnt<=1; after idx==WIDTH-1 is sampled -> STOP.
REQ-021 STOP: at cnt==OVERSAMPLE sample rx_s.
- 1: push {parity_err, shift} into the FIFO; -> IDLE.
- 0: framing_error<=1, word discarded; -> WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL -> IDLE only once rx_s==1; a held-low line (break) SHALL NOT start new frames.
REQ-023 parity_err SHALL be 1 when XOR of all WIDTH received bits == 0 (odd parity violated); the word is still stored.
REQ-024 A push SHALL occur on the clk edge that samples the stop bit; fifo_empty falls and rd_data is valid in the following cycle.
REQ-025 Pop: rd_en with !fifo_empty advances the head on that edge; rd_en while empty SHALL be ignored, with no pointer or count change.
REQ-026 Push when full without a same-cycle pop: word dropped, overflow<=1, FIFO contents unchanged.
REQ-027 Push and pop in the same cycle, including when full: both succeed; fifo_count unchanged.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH.
REQ-029 clr_errors SHALL clear both sticky flags next cycle; a set event in the same cycle SHALL win (flag stays 1).

Reset
REQ-030 On reset_n low, immediately:
- state=IDLE, cnt=0, idx=0, shift=0.
- FIFO pointers and fifo_count=0, fifo_empty=1, rd_data=0, rd_parity_err=0.
- busy=0, framing_error=0, overflow=0.
REQ-031 Reset mid-frame SHALL discard the partial frame; after release the block SHALL wait for a fresh falling edge (rx_s==0 in IDLE).

Verification (bench: WIDTH=8, OVERSAMPLE=4, FIFO_DEPTH=2)
REQ-032 Frame 0x01 with valid stop -> fifo_empty=0, rd_data=0x01, rd_parity_err=0, fifo_count=1; rd_en pulse -> fifo_empty=1.
REQ-033 Frame 0x03 -> stored, rd_data=0x03, rd_parity_err=1, framing_error=0.
REQ-034 Frame 0x01 with stop bit 0, then line held low 40 clk, then high -> framing_error=1, FIFO empty, busy=1 until line high, no spurious frame; clr_errors -> framing_error=0.
REQ-035 Frames 0x01, 0x07, 0x0B without reads -> fifo_count=2, overflow=1, pops yield 0x01 then 0x07; 0x0B lost.
REQ-036 1-clk low glitch on rx_in while idle -> busy pulses and returns to IDLE; no push, no flags.
REQ-037 reset_n asserted after bit 3 of a frame, released, then frame 0x01 -> only 0x01 stored; all outputs at reset values during reset.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver feeding a small first-word-fall-through FIFO.
//   Frame: start bit (0), WIDTH payload bits LSB first (bit WIDTH-1 is odd parity), stop bit (1).
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   rx_in               asynchronous serial line, idle high
//   rd_en               pop the FIFO head (ignored when empty)
//   rd_data             head word
//   rd_parity_err       parity flag stored with the head word
//   fifo_empty          FIFO holds no words
//   fifo_count          number of stored words
//   busy                receiver not in IDLE
//   framing_error       sticky, bad stop bit seen
//   overflow            sticky, word dropped because the FIFO was full
//   clr_errors          clears both sticky flags (a same-cycle set wins)
module uart_rx_fifo #(
   parameter int WIDTH      = 64,
   parameter int OVERSAMPLE = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              rx_in,
   input  logic                              rd_en,
   input  logic                              clr_errors,
   output logic [WIDTH-1:0]                  rd_data,
   output logic                              rd_parity_err,
   output logic                              fifo_empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              busy,
   output logic                              framing_error,
   output logic                              overflow
);

   localparam int CNT_W = $clog2(OVERSAMPLE + 1);
   localparam int IDX_W = $clog2(WIDTH);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int FCW   = $clog2(FIFO_DEPTH + 1);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [FCW-1:0]   FC_ONE   = FCW'(1);
   localparam logic [FCW-1:0]   FC_FULL  = FCW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic               rx_m_q, rx_s_q;
   logic               push, frm_set;

   logic [WIDTH:0]     mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FCW-1:0]     count_q, count_d;
   logic               frm_q, frm_d, ovf_q, ovf_d;
   logic               full, pop, wr, ovf_set, par_err;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_m_q <= 1'b1;
         rx_s_q <= 1'b1;
      end else begin
         rx_m_q <= rx_in;
         rx_s_q <= rx_m_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      push    = 1'b0;
      frm_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               cnt_d   = CNT_ONE;
            end
         end
         START: begin
            // Re-check mid start bit; a line already high again was a glitch.
            if (cnt_q == CNT_HALF) begin
               if (!rx_s_q) begin
                  state_d = DATA;
                  cnt_d   = CNT_ONE;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_q == CNT_FULL) begin
               shift_d[idx_q] = rx_s_q;
               cnt_d          = CNT_ONE;
               if (idx_q == IDX_LAST) state_d = STOP;
               else                   idx_d   = idx_q + IDX_ONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end else begin
                  frm_set = 1'b1;
                  state_d = WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         WAIT_IDLE: begin
            // A break holds the line low; only a return to idle re-arms the receiver.
            if (rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Odd parity over all received bits; the word is stored regardless.
   assign par_err = ~(^shift_q);

   assign full    = (count_q == FC_FULL);
   assign pop     = rd_en && (count_q != '0);
   assign wr      = push && (!full || pop);
   assign ovf_set = push && full && !pop;

   always_comb begin
      wr_ptr_d = wr  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      case ({wr, pop})
         2'b10:   count_d = count_q + FC_ONE;
         2'b01:   count_d = count_q - FC_ONE;
         default: count_d = count_q;
      endcase
      frm_d = (frm_q && !clr_errors) || frm_set;
      ovf_d = (ovf_q && !clr_errors) || ovf_set;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         frm_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr) mem_q[wr_ptr_q] <= {par_err, shift_q};
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         frm_q    <= frm_d;
         ovf_q    <= ovf_d;
      end
   end

   assign rd_data       = mem_q[rd_ptr_q][WIDTH-1:0];
   assign rd_parity_err = mem_q[rd_ptr_q][WIDTH];
   assign fifo_empty    = (count_q == '0);
   assign fifo_count    = count_q;
   assign busy          = (state_q != IDLE);
   assign framing_error = frm_q;
   assign overflow      = ovf_q;

endmodule
